// File: rtl/sevenseg_pkg.sv
// Shared constants and helpers for the serial 7-segment sequencer.
// SEVENSEG_SIGNED_EN widens the digit index to make room for the MINUS position.
package sevenseg_pkg;

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] CONVERT = 3'd1;
  localparam logic [2:0] SKIP    = 3'd2;
  localparam logic [2:0] SHOW    = 3'd3;
  localparam logic [2:0] GAP     = 3'd4;

  localparam logic [3:0] GLYPH_BLANK = 4'd10;
  localparam logic [3:0] GLYPH_MINUS = 4'd11;

  // Width of digit_idx: must also encode DIGITS (gap) and, when signed, DIGITS+1 (minus).
  function automatic int unsigned idx_w(input int unsigned digits);
`ifdef SEVENSEG_SIGNED_EN
    return $clog2(digits + 2);
`else
    return $clog2(digits + 1);
`endif
  endfunction

  // Segment pattern {g,f,e,d,c,b,a}, active-high.
  function automatic logic [6:0] seg_glyph(input logic [3:0] code);
    case (code)
      4'd0:        return 7'b0111111;
      4'd1:        return 7'b0000110;
      4'd2:        return 7'b1011011;
      4'd3:        return 7'b1001111;
      4'd4:        return 7'b1100110;
      4'd5:        return 7'b1101101;
      4'd6:        return 7'b1111101;
      4'd7:        return 7'b0000111;
      4'd8:        return 7'b1111111;
      4'd9:        return 7'b1101111;
      GLYPH_MINUS: return 7'b1000000;
      default:     return 7'b0000000;
    endcase
  endfunction

endpackage

// File: rtl/sevenseg_sequencer_if.sv
// Control/display bundle between the game logic and the segment sequencer.
interface sevenseg_sequencer_if #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned DIGITS = 3
);
  import sevenseg_pkg::*;

  localparam int unsigned IDX_W = idx_w(DIGITS);

  logic             start;
  logic             trigger;
  logic [WIDTH-1:0] value;
  logic [6:0]       seg;
  logic [IDX_W-1:0] digit_idx;
  logic             busy;
  logic             done;

  modport master (output start, trigger, value, input seg, digit_idx, busy, done);
  modport slave  (input start, trigger, value, output seg, digit_idx, busy, done);

endinterface

// File: rtl/sevenseg_sequencer_bin2bcd_seq.sv
// Serial double-dabble: the load cycle performs the first shift, so the BCD
// result is ready (valid) exactly WIDTH cycles after load.
module bin2bcd_seq #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned DIGITS = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic [WIDTH-1:0]      bin,
  output logic [DIGITS*4-1:0]   bcd,
  output logic                  valid
);
  localparam int unsigned BCD_W = DIGITS * 4;
  localparam int unsigned CNT_W = $clog2(WIDTH);

  logic [BCD_W-1:0]       bcd_q, bcd_d, src_bcd, adj;
  logic [WIDTH-1:0]       bin_q, bin_d, src_bin;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   valid_q, valid_d;
  logic [BCD_W+WIDTH-1:0] shifted;

  always_comb begin
    src_bcd = load ? '0 : bcd_q;
    src_bin = load ? bin : bin_q;
    adj     = src_bcd;
    for (int i = 0; i < int'(DIGITS); i++) begin
      if (src_bcd[i*4 +: 4] > 4'd4) adj[i*4 +: 4] = src_bcd[i*4 +: 4] + 4'd3;
    end
    shifted = {adj, src_bin} << 1;

    bcd_d   = bcd_q;
    bin_d   = bin_q;
    cnt_d   = cnt_q;
    valid_d = valid_q;
    if (load) begin
      {bcd_d, bin_d} = shifted;
      cnt_d          = CNT_W'(WIDTH - 1);
      valid_d        = 1'b0;
    end else if (cnt_q != '0) begin
      {bcd_d, bin_d} = shifted;
      cnt_d          = cnt_q - CNT_W'(1);
      valid_d        = (cnt_q == CNT_W'(1));
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      bcd_q   <= '0;
      bin_q   <= '0;
      cnt_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      bcd_q   <= bcd_d;
      bin_q   <= bin_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
    end
  end

  assign bcd   = bcd_q;
  assign valid = valid_q;

endmodule

// File: rtl/sevenseg_sequencer.sv
// Latches a binary value, converts it to BCD serially and plays the digits MSD-first
// on one 7-segment output, followed by a blank gap. SEVENSEG_SIGNED_EN: two's complement input.
module sevenseg_sequencer
  import sevenseg_pkg::*;
#(
  parameter int unsigned WIDTH        = 8,
  parameter int unsigned DIGITS       = 3,
  parameter int unsigned DWELL_CYCLES = 0
) (
  input logic                 clk,
  input logic                 rst,
  sevenseg_sequencer_if.slave bus
);
  localparam int unsigned BCD_W = DIGITS * 4;
  localparam int unsigned IDX_W = idx_w(DIGITS);
  localparam int unsigned DW_W  = (DWELL_CYCLES > 0) ? $clog2(DWELL_CYCLES + 1) : 1;
  localparam logic [DW_W-1:0]  DWELL_LAST = DW_W'((DWELL_CYCLES > 0) ? DWELL_CYCLES - 1 : 0);
  localparam logic [IDX_W-1:0] IDX_LSD    = IDX_W'(DIGITS - 1);
  localparam logic [IDX_W-1:0] IDX_GAP    = IDX_W'(DIGITS);
`ifdef SEVENSEG_SIGNED_EN
  localparam logic [IDX_W-1:0] IDX_MINUS  = IDX_W'(DIGITS + 1);
  logic neg_q, neg_d;
`endif

  logic [2:0]       state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [6:0]       seg_q, seg_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [DW_W-1:0]  dwell_q, dwell_d;

  logic             conv_load_c;
  logic [WIDTH-1:0] conv_bin_c;
  logic [BCD_W-1:0] bcd;
  logic             conv_valid;
  logic             adv_c;
  logic [IDX_W-1:0] lead_c;
  logic [3:0]       code_c;

  // Magnitude fed to the converter; |-2^(WIDTH-1)| still fits WIDTH unsigned bits.
  always_comb begin
    conv_bin_c = bus.value;
`ifdef SEVENSEG_SIGNED_EN
    if (bus.value[WIDTH-1]) conv_bin_c = ~bus.value + WIDTH'(1);
`endif
  end

  bin2bcd_seq #(
    .WIDTH  (WIDTH),
    .DIGITS (DIGITS)
  ) u_conv (
    .clk   (clk),
    .rst   (rst),
    .load  (conv_load_c),
    .bin   (conv_bin_c),
    .bcd   (bcd),
    .valid (conv_valid)
  );

  // Highest non-zero digit; a zero value falls back to the LSD.
  always_comb begin
    lead_c = IDX_LSD;
    for (int i = int'(DIGITS) - 2; i >= 0; i--) begin
      if (bcd[(int'(DIGITS) - 1 - i)*4 +: 4] != 4'd0) lead_c = IDX_W'(i);
    end
  end

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    dwell_d     = dwell_q;
    conv_load_c = 1'b0;
`ifdef SEVENSEG_SIGNED_EN
    neg_d       = neg_q;
`endif
    adv_c = (DWELL_CYCLES == 0) ? bus.trigger : (dwell_q == DWELL_LAST);

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d     = CONVERT;
          busy_d      = 1'b1;
          conv_load_c = 1'b1;
          idx_d       = '0;
`ifdef SEVENSEG_SIGNED_EN
          neg_d       = bus.value[WIDTH-1];
`endif
        end
      end
      CONVERT: if (conv_valid) state_d = SKIP;
      SKIP: begin
        state_d = SHOW;
        dwell_d = '0;
        idx_d   = lead_c;
`ifdef SEVENSEG_SIGNED_EN
        if (neg_q) idx_d = IDX_MINUS;
`endif
      end
      SHOW, GAP: begin
        dwell_d = dwell_q + DW_W'(1);
        if (adv_c) begin
          dwell_d = '0;
          if (state_q == GAP) begin
            state_d = IDLE;
            idx_d   = '0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else if (idx_q == IDX_LSD) begin
            state_d = GAP;
            idx_d   = IDX_GAP;
          end
`ifdef SEVENSEG_SIGNED_EN
          else if (idx_q == IDX_MINUS) idx_d = lead_c;
`endif
          else idx_d = idx_q + IDX_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Segments are registered from the next state so they change with digit_idx.
  always_comb begin
    code_c = GLYPH_BLANK;
    if (state_d == SHOW) begin
      for (int i = 0; i < int'(DIGITS); i++) begin
        if (idx_d == IDX_W'(i)) code_c = bcd[(int'(DIGITS) - 1 - i)*4 +: 4];
      end
`ifdef SEVENSEG_SIGNED_EN
      if (idx_d == IDX_MINUS) code_c = GLYPH_MINUS;
`endif
    end
    seg_d = seg_glyph(code_c);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      seg_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      dwell_q <= '0;
`ifdef SEVENSEG_SIGNED_EN
      neg_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      seg_q   <= seg_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      dwell_q <= dwell_d;
`ifdef SEVENSEG_SIGNED_EN
      neg_q   <= neg_d;
`endif
    end
  end

  assign bus.seg       = seg_q;
  assign bus.digit_idx = idx_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;

endmodule

// File: tb/tb_sevenseg_sequencer.sv
// Bench for sevenseg_sequencer: a trigger-mode instance and a DWELL_CYCLES=4 instance,
// checked against a decimal-arithmetic model of the displayed sequence.
module tb_sevenseg_sequencer;

  localparam int W  = 8;
  localparam int D  = 3;
  localparam int DW = 4;
`ifdef SEVENSEG_SIGNED_EN
  localparam int IW = $clog2(D + 2);
`else
  localparam int IW = $clog2(D + 1);
`endif
  localparam int NV = 7;

  typedef struct {
    logic [W-1:0] value;
    logic [6:0]   seg0;
    int           idx0;
    int           npos;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  sevenseg_sequencer_if #(.WIDTH(W), .DIGITS(D)) tif ();
  sevenseg_sequencer_if #(.WIDTH(W), .DIGITS(D)) aif ();

  sevenseg_sequencer #(.WIDTH(W), .DIGITS(D), .DWELL_CYCLES(0)) u_trig (
    .clk (clk), .rst (rst), .bus (tif)
  );
  sevenseg_sequencer #(.WIDTH(W), .DIGITS(D), .DWELL_CYCLES(DW)) u_auto (
    .clk (clk), .rst (rst), .bus (aif)
  );

  int checks   = 0;
  int failures = 0;

  logic [6:0]    gly [12];
  logic [6:0]    exp_seg [$];
  logic [IW-1:0] exp_idx [$];
  vec_t          vec [NV];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, expv);
    end
  endtask

  // Expected shown positions: optional minus, digits from the first non-zero one, then the gap.
  function automatic void model(input logic [W-1:0] v);
    int mag, p, first;
    int d [D];
    bit neg;
    exp_seg.delete();
    exp_idx.delete();
    neg = 1'b0;
    mag = int'(v);
`ifdef SEVENSEG_SIGNED_EN
    if (v[W-1]) begin
      neg = 1'b1;
      mag = (1 << W) - int'(v);
    end
`endif
    p = 1;
    for (int i = D - 1; i >= 0; i--) begin
      d[i] = (mag / p) % 10;
      p    = p * 10;
    end
    first = D - 1;
    for (int i = D - 2; i >= 0; i--) if (d[i] != 0) first = i;
    if (neg) begin
      exp_seg.push_back(gly[11]);
      exp_idx.push_back(IW'(D + 1));
    end
    for (int i = first; i < D; i++) begin
      exp_seg.push_back(gly[d[i]]);
      exp_idx.push_back(IW'(i));
    end
    exp_seg.push_back(7'b0000000);
    exp_idx.push_back(IW'(D));
  endfunction

  task automatic do_start(input logic [W-1:0] v, input bit with_trig);
    tif.value   = v;
    tif.start   = 1'b1;
    tif.trigger = with_trig;
  endtask

  // Called at the negedge where start was driven; returns at the negedge showing done.
  task automatic play_trig(input logic [W-1:0] v, input bit disturb,
                           output logic [6:0] f_seg, output int f_idx, output int npos);
    model(v);
    npos  = exp_seg.size() - 1;
    f_seg = 7'h7f;
    f_idx = -1;
    for (int k = 1; k <= W + 1; k++) begin
      @(negedge clk);
      tif.start   = 1'b0;
      tif.trigger = 1'b0;
      if (k == 1)     chk("busy_after_start", 32'(tif.busy), 32'd1);
      if (k == W + 1) chk("seg_blank_before_show", 32'(tif.seg), 32'd0);
      if (disturb && k == 2) begin
        tif.start   = 1'b1;
        tif.value   = 8'd99;
        tif.trigger = 1'b1;
      end
      if (disturb && k == W + 1) tif.trigger = 1'b1;
    end
    for (int j = 0; j < exp_seg.size(); j++) begin
      @(negedge clk);
      tif.trigger = 1'b0;
      chk("seg", 32'(tif.seg), 32'(exp_seg[j]));
      chk("digit_idx", 32'(tif.digit_idx), 32'(exp_idx[j]));
      chk("busy_show", 32'(tif.busy), 32'd1);
      chk("no_early_done", 32'(tif.done), 32'd0);
      if (j == 0) begin
        f_seg = tif.seg;
        f_idx = int'(tif.digit_idx);
      end
      repeat ($urandom_range(0, 2)) begin
        @(negedge clk);
        chk("seg_hold", 32'(tif.seg), 32'(exp_seg[j]));
      end
      tif.trigger = 1'b1;
    end
    @(negedge clk);
    tif.trigger = 1'b0;
    chk("done_pulse", 32'(tif.done), 32'd1);
    chk("busy_clear", 32'(tif.busy), 32'd0);
    chk("seg_idle", 32'(tif.seg), 32'd0);
    chk("idx_idle", 32'(tif.digit_idx), 32'd0);
  endtask

  // Auto-advance run with random (ignored) triggers; cyc counts cycles from start to done.
  task automatic play_auto(input logic [W-1:0] v, output int cyc);
    model(v);
    cyc         = 0;
    aif.value   = v;
    aif.start   = 1'b1;
    for (int k = 1; k <= W + 1; k++) begin
      @(negedge clk);
      cyc++;
      aif.start   = 1'b0;
      aif.trigger = 1'($urandom_range(0, 1));
      if (k == W + 1) chk("auto_seg_blank_before_show", 32'(aif.seg), 32'd0);
    end
    for (int j = 0; j < exp_seg.size(); j++) begin
      for (int c = 0; c < DW; c++) begin
        @(negedge clk);
        cyc++;
        aif.trigger = 1'($urandom_range(0, 1));
        chk("auto_seg", 32'(aif.seg), 32'(exp_seg[j]));
        chk("auto_idx", 32'(aif.digit_idx), 32'(exp_idx[j]));
      end
    end
    @(negedge clk);
    cyc++;
    aif.trigger = 1'b0;
    chk("auto_done", 32'(aif.done), 32'd1);
    chk("auto_busy_clear", 32'(aif.busy), 32'd0);
  endtask

  task automatic reset_mid(input int wait_cycles, input string tag);
    do_start(8'd123, 1'b0);
    repeat (wait_cycles) begin
      @(negedge clk);
      tif.start = 1'b0;
    end
    chk({tag, "_busy_before"}, 32'(tif.busy), 32'd1);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    chk({tag, "_seg"}, 32'(tif.seg), 32'd0);
    chk({tag, "_busy"}, 32'(tif.busy), 32'd0);
    chk({tag, "_idx"}, 32'(tif.digit_idx), 32'd0);
    chk({tag, "_done"}, 32'(tif.done), 32'd0);
    repeat (2) @(negedge clk);
    chk({tag, "_stays_idle"}, 32'({tif.busy, tif.done, tif.seg}), 32'd0);
  endtask

  initial begin
    logic [6:0] fs;
    int         fi, np, cyc;
    logic [W-1:0] v;

    gly = '{7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111, 7'b1100110, 7'b1101101,
            7'b1111101, 7'b0000111, 7'b1111111, 7'b1101111, 7'b0000000, 7'b1000000};
`ifdef SEVENSEG_SIGNED_EN
    vec[0] = '{8'hFB, 7'b1000000, 4, 2};
    vec[1] = '{8'h80, 7'b1000000, 4, 4};
    vec[2] = '{8'h05, 7'b1101101, 2, 1};
    vec[3] = '{8'h00, 7'b0111111, 2, 1};
    vec[4] = '{8'h7F, 7'b0000110, 0, 3};
    vec[5] = '{8'hFF, 7'b1000000, 4, 2};
    vec[6] = '{8'hD6, 7'b1000000, 4, 3};
`else
    vec[0] = '{8'd205, 7'b1011011, 0, 3};
    vec[1] = '{8'd7,   7'b0000111, 2, 1};
    vec[2] = '{8'd0,   7'b0111111, 2, 1};
    vec[3] = '{8'd100, 7'b0000110, 0, 3};
    vec[4] = '{8'd42,  7'b1100110, 1, 2};
    vec[5] = '{8'd255, 7'b1011011, 0, 3};
    vec[6] = '{8'd10,  7'b0000110, 1, 2};
`endif

    tif.start = 1'b0; tif.trigger = 1'b0; tif.value = '0;
    aif.start = 1'b0; aif.trigger = 1'b0; aif.value = '0;
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_trig", 32'({tif.seg, tif.digit_idx, tif.busy, tif.done}), 32'd0);
    chk("reset_auto", 32'({aif.seg, aif.digit_idx, aif.busy, aif.done}), 32'd0);
    rst = 1'b1;
    @(negedge clk);

    // Triggers while idle must not start anything
    for (int i = 0; i < 3; i++) begin
      tif.trigger = 1'b1;
      @(negedge clk);
      chk("idle_trigger", 32'({tif.seg, tif.digit_idx, tif.busy, tif.done}), 32'd0);
    end
    tif.trigger = 1'b0;

    // Table: first glyph, first index and shown-position count per value
    for (int t = 0; t < NV; t++) begin
      do_start(vec[t].value, t == 1);
      play_trig(vec[t].value, t == 0, fs, fi, np);
      chk("tbl_first_seg", 32'(fs), 32'(vec[t].seg0));
      chk("tbl_first_idx", 32'(fi), 32'(vec[t].idx0));
      chk("tbl_npos", 32'(np), 32'(vec[t].npos));
      @(negedge clk);
      chk("done_one_cycle", 32'(tif.done), 32'd0);
    end

    // Start accepted in the same cycle done is high, then random values back to back
    do_start(8'd58, 1'b0);
    play_trig(8'd58, 1'b0, fs, fi, np);
    repeat (20) begin
      v = W'($urandom);
      do_start(v, 1'($urandom_range(0, 1)));
      play_trig(v, 1'($urandom_range(0, 1)), fs, fi, np);
    end
    @(negedge clk);

    reset_mid(W + 4, "rst_show");
    reset_mid(3, "rst_convert");
    do_start(8'd205, 1'b0);
    play_trig(8'd205, 1'b0, fs, fi, np);
    @(negedge clk);

    play_auto(8'd123, cyc);
    chk("auto_latency_123", 32'(cyc), 32'(8 + 2 + 16));
    repeat (4) begin
      @(negedge clk);
      play_auto(W'($urandom), cyc);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
